// File: rtl/collision_event_queue.sv
// collision_event_queue
//   Detects ball-ball, ball-wall and ball-hole overlaps from per-pixel draw
//   requests, de-duplicates them once per frame, and queues each distinct
//   event in a show-ahead FIFO drained via a valid/ready handshake. It also
//   tracks which balls are still on the table; pocketed balls are masked
//   from all further detection.
//
//   Optional build macro: COLLISION_TIMESTAMP_EN adds an 8-bit frame counter
//   stored with each FIFO entry and presented on evt_frame.
//
// Ports
//   clk, resetN        clock, asynchronous active-low reset
//   startOfFrame       frame pulse: clears seen-bits and overflow
//   rack_reset         new game: flush FIFO, restore all balls, clear state
//   Balls_DR_VEC       per-ball draw request for the current pixel
//   Table_DR           wall code (00 = no wall)
//   Hole_DR, Hole_ID   hole draw request and hole index
//   evt_valid/ready    FIFO head handshake
//   evt_type           01 ball-ball, 10 ball-wall, 11 ball-hole
//   evt_id_a/_b        lower/higher ball index (b only for ball-ball)
//   evt_aux            wall code or hole index
//   evt_frame          frame counter at push time (timestamp build only)
//   balls_in_game      1 = ball still on the table
//   overflow           sticky: an event was dropped this frame
//   collision          combinational: any masked collision on this pixel
module collision_event_queue #(
  parameter int unsigned NUM_BALLS  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned ID_W      = $clog2(NUM_BALLS)
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 rack_reset,
  input  logic [NUM_BALLS-1:0] Balls_DR_VEC,
  input  logic [1:0]           Table_DR,
  input  logic                 Hole_DR,
  input  logic [2:0]           Hole_ID,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [1:0]           evt_type,
  output logic [ID_W-1:0]      evt_id_a,
  output logic [ID_W-1:0]      evt_id_b,
  output logic [2:0]           evt_aux,
`ifdef COLLISION_TIMESTAMP_EN
  output logic [7:0]           evt_frame,
`endif
  output logic [NUM_BALLS-1:0] balls_in_game,
  output logic                 overflow,
  output logic                 collision
);

  localparam int unsigned PAIRS   = NUM_BALLS * (NUM_BALLS - 1) / 2;
  localparam int unsigned PAIR_IW = $clog2(PAIRS);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  localparam logic [1:0] EVT_BB   = 2'b01;
  localparam logic [1:0] EVT_WALL = 2'b10;
  localparam logic [1:0] EVT_HOLE = 2'b11;

  typedef struct packed {
    logic [1:0]      etype;
    logic [ID_W-1:0] id_a;
    logic [ID_W-1:0] id_b;
    logic [2:0]      aux;
  } evt_t;

  typedef struct packed {
`ifdef COLLISION_TIMESTAMP_EN
    logic [7:0] frame;
`endif
    evt_t       ev;
  } entry_t;

  // Detection
  logic [NUM_BALLS-1:0] act;
  logic                 found_a;
  logic                 found_b;
  logic [ID_W-1:0]      idx_a;
  logic [ID_W-1:0]      idx_b;
  logic [PAIR_IW-1:0]   pair_idx;

  // Seen-bits
  logic [NUM_BALLS-1:0] hole_seen, hole_seen_n, hole_base;
  logic [NUM_BALLS-1:0] wall_seen, wall_seen_n, wall_base;
  logic [PAIRS-1:0]     pair_seen, pair_seen_n, pair_base;

  // Candidate and stage 1
  evt_t cand;
  logic cand_any;
  logic cand_hit;
  logic cand_push;
  logic s1_valid, s1_valid_n;
  evt_t s1_evt, s1_evt_n;

  // FIFO
  entry_t             mem [FIFO_DEPTH];
  entry_t             head_q, head_n;
  entry_t             push_entry;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0]   rd_ptr_inc;
  logic [CNT_W-1:0]   count, count_n;
  logic               valid_n;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic               drop;
  logic               wr_en;

  logic [NUM_BALLS-1:0] balls_n;
  logic                 overflow_n;

`ifdef COLLISION_TIMESTAMP_EN
  logic [7:0] frame_cnt, frame_cnt_n;
`endif

  // Lowest and second-lowest in-game ball on this pixel
  always_comb begin
    act     = Balls_DR_VEC & balls_in_game;
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    for (int unsigned i = 0; i < NUM_BALLS; i++) begin
      if (act[i]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = ID_W'(i);
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = ID_W'(i);
        end
      end
    end
  end

  // Row-major index of (a,b), a<b, in the upper triangle of the pair matrix
  always_comb begin
    pair_idx = '0;
    if (found_b) begin
      pair_idx = PAIR_IW'(((32'(idx_a) * (2 * NUM_BALLS - 32'(idx_a) - 32'd1)) >> 1)
                          + 32'(idx_b) - 32'(idx_a) - 32'd1);
    end
  end

  assign collision = (found_a && (Hole_DR || (Table_DR != 2'b00))) || found_b;

  // A frame start clears the seen-bits before this pixel's candidate is checked
  assign hole_base = startOfFrame ? '0 : hole_seen;
  assign wall_base = startOfFrame ? '0 : wall_seen;
  assign pair_base = startOfFrame ? '0 : pair_seen;

  // Candidate selection (hole > ball-ball > wall), de-dup and seen-bit update
  always_comb begin
    cand        = '0;
    cand_any    = 1'b0;
    cand_hit    = 1'b0;
    hole_seen_n = hole_base;
    wall_seen_n = wall_base;
    pair_seen_n = pair_base;
    if (Hole_DR && found_a) begin
      cand_any   = 1'b1;
      cand.etype = EVT_HOLE;
      cand.id_a  = idx_a;
      cand.aux   = Hole_ID;
      cand_hit   = hole_base[idx_a];
    end else if (found_b) begin
      cand_any   = 1'b1;
      cand.etype = EVT_BB;
      cand.id_a  = idx_a;
      cand.id_b  = idx_b;
      cand_hit   = pair_base[pair_idx];
    end else if ((Table_DR != 2'b00) && found_a) begin
      cand_any   = 1'b1;
      cand.etype = EVT_WALL;
      cand.id_a  = idx_a;
      cand.aux   = {1'b0, Table_DR};
      cand_hit   = wall_base[idx_a];
    end
    cand_push = cand_any && !cand_hit;
    if (cand_push) begin
      case (cand.etype)
        EVT_HOLE: hole_seen_n[idx_a]    = 1'b1;
        EVT_BB:   pair_seen_n[pair_idx] = 1'b1;
        default:  wall_seen_n[idx_a]    = 1'b1;
      endcase
    end
    if (rack_reset) begin
      hole_seen_n = '0;
      wall_seen_n = '0;
      pair_seen_n = '0;
    end
    s1_valid_n = cand_push && !rack_reset;
    s1_evt_n   = cand;
  end

  // FIFO control, registered show-ahead head, pocketing and overflow
  always_comb begin
    pop        = evt_valid && evt_ready;
    full       = (count == CNT_W'(FIFO_DEPTH));
    push_ok    = s1_valid && (!full || pop);
    drop       = s1_valid && full && !pop;
    wr_en      = push_ok && !rack_reset;
    rd_ptr_inc = rd_ptr + PTR_W'(1);
    push_entry = '0;
    push_entry.ev = s1_evt;
`ifdef COLLISION_TIMESTAMP_EN
    push_entry.frame = frame_cnt;
`endif
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    count_n    = count;
    head_n     = head_q;
    valid_n    = evt_valid;
    balls_n    = balls_in_game;
    overflow_n = (startOfFrame ? 1'b0 : overflow) | drop;

    if (rack_reset) begin
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      count_n    = '0;
      head_n     = '0;
      valid_n    = 1'b0;
      balls_n    = '1;
      overflow_n = 1'b0;
    end else begin
      if (push_ok) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr_n = rd_ptr_inc;
      count_n = count + CNT_W'(push_ok) - CNT_W'(pop);
      if (pop) begin
        if (count > CNT_W'(1)) begin
          head_n  = mem[rd_ptr_inc];
          valid_n = 1'b1;
        end else if (push_ok) begin
          head_n  = push_entry;
          valid_n = 1'b1;
        end else begin
          head_n  = '0;
          valid_n = 1'b0;
        end
      end else if (push_ok && (count == '0)) begin
        head_n  = push_entry;
        valid_n = 1'b1;
      end
      // A hole event pockets its ball even if the push itself is dropped
      if (s1_valid && (s1_evt.etype == EVT_HOLE)) balls_n[s1_evt.id_a] = 1'b0;
    end
  end

`ifdef COLLISION_TIMESTAMP_EN
  always_comb begin
    frame_cnt_n = frame_cnt;
    if (rack_reset)        frame_cnt_n = '0;
    else if (startOfFrame) frame_cnt_n = frame_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) frame_cnt <= '0;
    else         frame_cnt <= frame_cnt_n;
  end

  assign evt_frame = head_q.frame;
`endif

  // State registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hole_seen     <= '0;
      wall_seen     <= '0;
      pair_seen     <= '0;
      s1_valid      <= 1'b0;
      s1_evt        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      head_q        <= '0;
      evt_valid     <= 1'b0;
      balls_in_game <= '1;
      overflow      <= 1'b0;
    end else begin
      hole_seen     <= hole_seen_n;
      wall_seen     <= wall_seen_n;
      pair_seen     <= pair_seen_n;
      s1_valid      <= s1_valid_n;
      s1_evt        <= s1_evt_n;
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      count         <= count_n;
      head_q        <= head_n;
      evt_valid     <= valid_n;
      balls_in_game <= balls_n;
      overflow      <= overflow_n;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign evt_type = head_q.ev.etype;
  assign evt_id_a = head_q.ev.id_a;
  assign evt_id_b = head_q.ev.id_b;
  assign evt_aux  = head_q.ev.aux;

endmodule

// File: tb/tb_collision_event_queue.sv
// Testbench for collision_event_queue: table-driven single-pixel vectors,
// directed multi-cycle sequences and randomized traffic, all checked against
// a queue-based reference model of the event rules.
module tb_collision_event_queue;

  localparam int NB    = 16;
  localparam int DEPTH = 8;

  logic        clk;
  logic        resetN;
  logic        sof;
  logic        rack;
  logic [15:0] balls;
  logic [1:0]  tdr;
  logic        hdr;
  logic [2:0]  hid;
  logic        evt_ready;
  logic        evt_valid;
  logic [1:0]  evt_type;
  logic [3:0]  evt_id_a;
  logic [3:0]  evt_id_b;
  logic [2:0]  evt_aux;
  logic [15:0] balls_in_game;
  logic        overflow;
  logic        collision;
`ifdef COLLISION_TIMESTAMP_EN
  logic [7:0]  evt_frame;
`endif

  collision_event_queue #(.NUM_BALLS(NB), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (sof),
    .rack_reset    (rack),
    .Balls_DR_VEC  (balls),
    .Table_DR      (tdr),
    .Hole_DR       (hdr),
    .Hole_ID       (hid),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_type      (evt_type),
    .evt_id_a      (evt_id_a),
    .evt_id_b      (evt_id_b),
    .evt_aux       (evt_aux),
`ifdef COLLISION_TIMESTAMP_EN
    .evt_frame     (evt_frame),
`endif
    .balls_in_game (balls_in_game),
    .overflow      (overflow),
    .collision     (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic col_seen;

  // ---------------- reference model ----------------
  typedef struct { int t; int a; int b; int aux; } ev_t;
  ev_t         mq[$];
  logic [15:0] m_ingame;
  bit          m_hole [NB];
  bit          m_wall [NB];
  bit          m_pair [NB][NB];
  bit          m_pv;
  ev_t         m_pend;
  bit          m_ovf;

  task automatic m_clear_seen();
    for (int i = 0; i < NB; i++) begin
      m_hole[i] = 0;
      m_wall[i] = 0;
      for (int j = 0; j < NB; j++) m_pair[i][j] = 0;
    end
  endtask

  task automatic m_clear();
    mq.delete();
    m_ingame = 16'hFFFF;
    m_clear_seen();
    m_pv   = 0;
    m_pend = '{0, 0, 0, 0};
    m_ovf  = 0;
  endtask

  task automatic m_scan(output int cnt, output int a, output int b);
    logic [15:0] v;
    v = balls & m_ingame;
    cnt = 0; a = 0; b = 0;
    for (int i = 0; i < NB; i++) begin
      if (v[i]) begin
        if (cnt == 0) a = i;
        else if (cnt == 1) b = i;
        cnt++;
      end
    end
  endtask

  function automatic bit m_collision();
    int c;
    c = $countones(balls & m_ingame);
    return (c >= 1 && (hdr || tdr != 2'b00)) || c >= 2;
  endfunction

  // Advance the model across one rising edge using the current inputs
  task automatic m_edge();
    int cnt, a, b;
    bit pop, drop, cv;
    ev_t c;
    pop = (mq.size() != 0) && evt_ready;
    if (rack) begin
      m_clear();
      return;
    end
    m_scan(cnt, a, b);
    if (sof) m_clear_seen();
    cv = 0;
    c  = '{0, 0, 0, 0};
    if (hdr && cnt >= 1) begin
      if (!m_hole[a]) begin m_hole[a] = 1; cv = 1; c = '{3, a, 0, int'(hid)}; end
    end else if (cnt >= 2) begin
      if (!m_pair[a][b]) begin m_pair[a][b] = 1; cv = 1; c = '{1, a, b, 0}; end
    end else if (tdr != 2'b00 && cnt >= 1) begin
      if (!m_wall[a]) begin m_wall[a] = 1; cv = 1; c = '{2, a, 0, int'(tdr)}; end
    end
    drop = 0;
    if (pop) void'(mq.pop_front());
    if (m_pv) begin
      if (m_pend.t == 3) m_ingame[m_pend.a] = 1'b0;
      if (mq.size() < DEPTH) mq.push_back(m_pend);
      else drop = 1;
    end
    if (sof)  m_ovf = 0;
    if (drop) m_ovf = 1;
    m_pv   = cv;
    m_pend = c;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic px(input logic [15:0] bv, input logic [1:0] t, input logic h, input logic [2:0] id);
    balls = bv; tdr = t; hdr = h; hid = id;
  endtask

  // One clock: check collision mid-cycle, advance model, check registered outputs
  task automatic step();
    @(negedge clk);
    col_seen = collision;
    chk("collision", 32'(collision), 32'(m_collision()));
    m_edge();
    @(posedge clk);
    #1;
    sof  = 1'b0;
    rack = 1'b0;
    chk("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("evt_type", 32'(evt_type), 32'(mq[0].t));
      chk("evt_id_a", 32'(evt_id_a), 32'(mq[0].a));
      chk("evt_id_b", 32'(evt_id_b), 32'(mq[0].b));
      chk("evt_aux",  32'(evt_aux),  32'(mq[0].aux));
    end
    chk("balls_in_game", 32'(balls_in_game), 32'(m_ingame));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    px(16'h0, 2'b00, 1'b0, 3'd0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_rack();
    rack = 1'b1;
    idle(1);
  endtask

  // ---------------- single-pixel vector table ----------------
  typedef struct {
    logic [15:0] bv;
    logic [1:0]  t;
    logic        h;
    logic [2:0]  id;
    logic        e_col;
    logic        e_evt;
    logic [1:0]  e_type;
    logic [3:0]  e_a;
    logic [3:0]  e_b;
    logic [2:0]  e_aux;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{16'h0000, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 4'd0,  4'd0,  3'd0};
    vt[1] = '{16'h0001, 2'b01, 1'b0, 3'd0, 1'b1, 1'b1, 2'b10, 4'd0,  4'd0,  3'd1};
    vt[2] = '{16'h0001, 2'b00, 1'b1, 3'd4, 1'b1, 1'b1, 2'b11, 4'd0,  4'd0,  3'd4};
    vt[3] = '{16'h0006, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 2'b01, 4'd1,  4'd2,  3'd0};
    vt[4] = '{16'h8001, 2'b11, 1'b0, 3'd0, 1'b1, 1'b1, 2'b01, 4'd0,  4'd15, 3'd0};
    vt[5] = '{16'h0300, 2'b00, 1'b1, 3'd7, 1'b1, 1'b1, 2'b11, 4'd8,  4'd0,  3'd7};
    vt[6] = '{16'h0001, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 4'd0,  4'd0,  3'd0};
    vt[7] = '{16'h00E0, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 2'b01, 4'd5,  4'd6,  3'd0};
    vt[8] = '{16'h0000, 2'b11, 1'b1, 3'd3, 1'b0, 1'b0, 2'b00, 4'd0,  4'd0,  3'd0};
    vt[9] = '{16'h4000, 2'b10, 1'b0, 3'd0, 1'b1, 1'b1, 2'b10, 4'd14, 4'd0,  3'd2};

    // Reset
    resetN = 1'b0; sof = 1'b0; rack = 1'b0; evt_ready = 1'b0;
    px(16'h0, 2'b00, 1'b0, 3'd0);
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_balls", 32'(balls_in_game), 32'hFFFF);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_collision", 32'(collision), 32'd0);
    chk("rst_type", 32'(evt_type), 32'd0);
    chk("rst_ids", 32'({evt_id_a, evt_id_b, evt_aux}), 32'd0);
    resetN = 1'b1;
    idle(2);

    // Table-driven vectors, each from a fresh rack
    for (int k = 0; k < 10; k++) begin
      evt_ready = 1'b0;
      do_rack();
      px(vt[k].bv, vt[k].t, vt[k].h, vt[k].id);
      step();
      chk($sformatf("vec%0d_col", k), 32'(col_seen), 32'(vt[k].e_col));
      idle(1);
      chk($sformatf("vec%0d_valid", k), 32'(evt_valid), 32'(vt[k].e_evt));
      if (vt[k].e_evt) begin
        chk($sformatf("vec%0d_type", k), 32'(evt_type), 32'(vt[k].e_type));
        chk($sformatf("vec%0d_a", k),    32'(evt_id_a), 32'(vt[k].e_a));
        chk($sformatf("vec%0d_b", k),    32'(evt_id_b), 32'(vt[k].e_b));
        chk($sformatf("vec%0d_aux", k),  32'(evt_aux),  32'(vt[k].e_aux));
      end
      evt_ready = 1'b1;
      idle(1);
    end

    // Same pair held 3 cycles: one event after 2 cycles; again next frame
    evt_ready = 1'b1;
    do_rack();
    px(16'h0005, 2'b00, 1'b0, 3'd0);
    step();
    chk("pair_lat1_valid", 32'(evt_valid), 32'd0);
    step();
    chk("pair_lat2_valid", 32'(evt_valid), 32'd1);
    chk("pair_type", 32'(evt_type), 32'd1);
    chk("pair_a", 32'(evt_id_a), 32'd0);
    chk("pair_b", 32'(evt_id_b), 32'd2);
    step();
    chk("pair_after_pop", 32'(evt_valid), 32'd0);
    idle(3);
    chk("pair_dedup", 32'(evt_valid), 32'd0);
    sof = 1'b1;
    px(16'h0005, 2'b00, 1'b0, 3'd0);
    step();
    idle(1);
    chk("pair_newframe_valid", 32'(evt_valid), 32'd1);
    chk("pair_newframe_b", 32'(evt_id_b), 32'd2);
    idle(2);

    // Pocketing masks the ball from later detection
    evt_ready = 1'b0;
    do_rack();
    px(16'h0008, 2'b00, 1'b1, 3'd5);
    step();
    idle(1);
    chk("hole_valid", 32'(evt_valid), 32'd1);
    chk("hole_type", 32'(evt_type), 32'd3);
    chk("hole_a", 32'(evt_id_a), 32'd3);
    chk("hole_aux", 32'(evt_aux), 32'd5);
    chk("hole_balls", 32'(balls_in_game), 32'hFFF7);
    evt_ready = 1'b1;
    idle(1);
    px(16'h0008, 2'b01, 1'b0, 3'd0);
    step();
    chk("pocketed_col", 32'(col_seen), 32'd0);
    idle(2);
    chk("pocketed_no_evt", 32'(evt_valid), 32'd0);

    // Asynchronous reset with a hole event in flight: no partial push
    evt_ready = 1'b0;
    do_rack();
    px(16'h0010, 2'b00, 1'b1, 3'd2);
    step();
    resetN = 1'b0;
    #1;
    chk("async_rst_valid", 32'(evt_valid), 32'd0);
    chk("async_rst_balls", 32'(balls_in_game), 32'hFFFF);
    m_clear();
    #2;
    resetN = 1'b1;
    idle(3);
    chk("async_rst_no_push", 32'(evt_valid), 32'd0);

    // Overflow: 10 distinct walls, 8 kept in order, overflow cleared by frame
    evt_ready = 1'b0;
    do_rack();
    sof = 1'b1;
    idle(1);
    for (int i = 0; i < 10; i++) begin
      px(16'(1 << i), 2'b10, 1'b0, 3'd0);
      step();
    end
    idle(2);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovf_pop%0d_a", k), 32'(evt_id_a), 32'(k));
      chk($sformatf("ovf_pop%0d_aux", k), 32'(evt_aux), 32'd2);
      idle(1);
    end
    chk("ovf_drained", 32'(evt_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    sof = 1'b1;
    idle(1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with pop and push on the same edge
    evt_ready = 1'b0;
    do_rack();
    sof = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      px(16'(1 << i), 2'b10, 1'b0, 3'd0);
      step();
    end
    idle(2);
    px(16'h0100, 2'b10, 1'b0, 3'd0);
    step();
    evt_ready = 1'b1;
    idle(1);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("full_pp_pop%0d", k), 32'(evt_id_a), 32'(k));
      idle(1);
    end
    chk("full_pp_empty", 32'(evt_valid), 32'd0);

    // rack_reset wins over startOfFrame and a same-cycle collision
    evt_ready = 1'b0;
    do_rack();
    sof = 1'b1;
    idle(1);
    px(16'h0008, 2'b00, 1'b1, 3'd1); step();
    px(16'h0080, 2'b00, 1'b1, 3'd2); step();
    px(16'h0001, 2'b01, 1'b0, 3'd0); step();
    idle(2);
    chk("rack_pre_balls", 32'(balls_in_game), 32'hFF77);
    chk("rack_pre_valid", 32'(evt_valid), 32'd1);
    rack = 1'b1;
    sof  = 1'b1;
    px(16'h0003, 2'b00, 1'b0, 3'd0);
    step();
    chk("rack_valid", 32'(evt_valid), 32'd0);
    chk("rack_balls", 32'(balls_in_game), 32'hFFFF);
    chk("rack_ovf", 32'(overflow), 32'd0);
    idle(3);
    chk("rack_killed", 32'(evt_valid), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] bv;
      int nb;
      bv = 16'h0;
      nb = $urandom_range(0, 3);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 1) == 0) bv[$urandom_range(0, 5)] = 1'b1;
        else                           bv[$urandom_range(0, 15)] = 1'b1;
      end
      px(bv,
         ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
         ($urandom_range(0, 11) == 0),
         3'($urandom_range(0, 7)));
      sof  = ($urandom_range(0, 19) == 0);
      rack = ($urandom_range(0, 299) == 0);
      if (((n / 200) % 2) == 1) evt_ready = ($urandom_range(0, 3) == 0);
      else                      evt_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/collision_event_queue.md
Name: collision_event_queue

Overview:
Parametrised successor to the single-event game controller. Detects ball-ball, ball-wall and ball-hole overlaps from per-pixel draw requests for NUM_BALLS balls, and de-duplicates them per frame. Events are queued in a FIFO and handed to the movement/physics block through a valid/ready handshake, so every distinct collision in a frame is reported, not just the first. It also tracks which balls are still in game; pocketed balls are masked from all further detection.

Parameters:
NUM_BALLS, 16, number of balls; ball 0 is the white ball
FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2
ID_W, $clog2(NUM_BALLS), localparam, ball index width

Ports:
clk  in  1  system clock
resetN  in  1  reset
startOfFrame  in  1  one-cycle pulse at the start of each frame
rack_reset  in  1  one-cycle pulse; starts a new game
Balls_DR_VEC  in  NUM_BALLS  per-ball draw request for the current pixel
Table_DR  in  2  wall draw request; 00 = none, otherwise wall code
Hole_DR  in  1  hole draw request
Hole_ID  in  3  hole index, valid while Hole_DR is high
evt_valid  out  1  event available at the FIFO head
evt_ready  in  1  consumer accepts the head event
evt_type  out  2  01 = ball-ball, 10 = ball-wall, 11 = ball-hole
evt_id_a  out  ID_W  lower ball index
evt_id_b  out  ID_W  higher ball index (ball-ball only, else 0)
evt_aux  out  3  wall code (ball-wall, zero-extended) or Hole_ID (ball-hole), else 0
balls_in_game  out  NUM_BALLS  1 = ball on table
overflow  out  1  sticky: an event was dropped this frame
collision  out  1  combinational: any masked collision on the current pixel

Behaviour:
- Reset: clk, with reset resetN asynchronous, active-low. All state cleared: FIFO empty, evt_valid=0, evt_type/evt_id_a/evt_id_b/evt_aux=0, balls_in_game=all ones, overflow=0, seen-bits=0.
- Masking: act = Balls_DR_VEC & balls_in_game. cnt = popcount(act). a = lowest set index of act, b = second-lowest set index.
- Candidate event for the current pixel, one per cycle, in priority order:
  - HOLE if Hole_DR and cnt>=1.
  - BALL-BALL if cnt>=2, for pair (a,b).
  - WALL if Table_DR!=0 and cnt>=1.
- collision = (cnt>=1 && (Hole_DR || Table_DR!=0)) || cnt>=2.
- De-duplication uses seen-bits: hole_seen[NUM_BALLS], wall_seen[NUM_BALLS], and pair_seen for the upper triangle (NUM_BALLS*(NUM_BALLS-1)/2 bits).
  - A candidate whose seen-bit is set is discarded.
  - Otherwise its seen-bit is set and the event is pushed.
- startOfFrame clears all seen-bits and overflow.
  - If a candidate occurs in the same cycle, the clear happens first and the candidate is evaluated as belonging to the new frame.
- Pipeline: stage 1 registers the candidate and its seen-check; stage 2 writes the FIFO.
  - For a pixel at cycle N, evt_valid is asserted at N+2 when the FIFO was empty.
  - The FIFO is show-ahead: head fields are valid whenever evt_valid=1.
- Handshake:
  - A pop occurs when evt_valid && evt_ready.
  - Head fields and evt_valid are held stable until the pop.
  - evt_ready while empty has no effect.
- Full FIFO:
  - A push with no pop in the same cycle is dropped, overflow is set to 1, and the seen-bit stays set (no retry).
  - A push with a pop in the same cycle is accepted; occupancy is unchanged.
- Pocketing: a HOLE event clears balls_in_game[a] in the same cycle it is pushed. A dropped HOLE event still clears the bit.
- The FIFO is NOT flushed at startOfFrame; events from the previous frame still drain.
- rack_reset:
  - Synchronous; flushes the FIFO (evt_valid=0 next cycle), sets balls_in_game to all ones, clears seen-bits and overflow, and kills the in-flight stage-1 event.
  - It takes priority over startOfFrame and over any push in the same cycle.
- Reset asserted mid-operation: immediate return to reset values, with no partial push.

Optional Feature:
COLLISION_TIMESTAMP_EN
- Defined:
  - Adds an 8-bit frame counter, incremented on startOfFrame, wrapping 255->0, and cleared by reset and rack_reset.
  - Each FIFO entry stores the counter value at push time.
  - A new output port evt_frame (out, 8) presents the head entry's value.
- Undefined: no counter, no evt_frame port, and FIFO width is reduced accordingly.

Test Plan:
1. Reset, then check outputs -> balls_in_game=16'hFFFF, evt_valid=0, overflow=0, collision=0.
2. Balls_DR_VEC=16'h0005 for 3 consecutive cycles, evt_ready=1 -> exactly one event {type=01, a=0, b=2}, evt_valid rises 2 cycles after the first pixel; the same pair in the next frame produces one new event.
3. Balls_DR_VEC=16'h0008 with Hole_DR=1, Hole_ID=5 -> event {type=11, a=3, aux=5}, balls_in_game[3]=0; a later pixel with Balls_DR_VEC=16'h0008 and Table_DR=2'b01 -> no event and collision=0.
4. Hold evt_ready=0; produce 10 distinct wall events in one frame (balls 0..9, Table_DR=2'b10) -> 8 queued, overflow=1; pop all -> balls 0..7 in order, each with aux=2; next startOfFrame -> overflow=0.
5. FIFO full, evt_ready=1 and a new distinct event in the same cycle -> push accepted, occupancy stays 8, no overflow.
6. FIFO holds 3 events and balls 3,7 are pocketed; pulse rack_reset together with startOfFrame and a collision -> next cycle evt_valid=0, balls_in_game=16'hFFFF, and the collision is not reported.
